// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the branch direction predictor and resolve stage:
//   - conditional-branch funct3 encodings
//   - the 2-bit saturating counter type and its reset value
//   - helper functions for the taken decode, funct3 legality and the
//     saturating counter update
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken.
    localparam bht_ctr_t BHT_CTR_RST = 2'b01;

    // 010 and 011 are not conditional branches.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3[2:1] != 2'b01);
    endfunction

    // Real branch outcome from the comparator flags. The signed/unsigned
    // choice is already made by the comparator via BrUn, so BLT/BLTU and
    // BGE/BGEU share a flag here.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       br_eq,
                                          input logic       br_lt,
                                          input logic       br_ge);
        logic t;
        case (f3)
            F3_BEQ:           t = br_eq;
            F3_BNE:           t = ~br_eq;
            F3_BLT, F3_BLTU:  t = br_lt;
            F3_BGE, F3_BGEU:  t = br_ge;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

    // Saturating 2-bit update: taken counts up to 11, not taken down to 00.
    function automatic bht_ctr_t ctr_update(input bht_ctr_t c, input logic taken);
        bht_ctr_t n;
        if (taken) begin
            n = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            n = (c == 2'b00) ? c : c - 2'b01;
        end
        return n;
    endfunction

endpackage

// File: rtl/bht_table.sv
// -----------------------------------------------------------------------------
// bht_table
// Array of 2-bit saturating counters with one combinational read port and one
// training write port.
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset, all counters -> BHT_CTR_RST
//   rd_idx_i     in   lookup index
//   rd_taken_o   out  MSB of the counter at rd_idx_i (predicted direction)
//   wr_en_i      in   apply a training update this cycle
//   wr_idx_i     in   index to train
//   wr_taken_i   in   resolved direction used for the saturating update
// A read of the index being written in the same cycle returns the old value,
// since the array only changes at the clock edge.
// -----------------------------------------------------------------------------
module bht_table
    import riscv_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    bht_ctr_t ctr_q [ENTRIES];

    assign rd_taken_o = ctr_q[rd_idx_i][1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_CTR_RST;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_update(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
// Direction predictor (IF side) and branch resolution (EX side).
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_pc_i               fetch PC; pred_taken_o is its predicted direction
//   ex_valid_i/ex_stall_i EX holds a live instruction / EX is held
//   ex_is_branch_i        conditional branch in EX
//   ex_is_jump_i          JAL/JALR in EX (wins over ex_is_branch_i)
//   ex_funct3_i           branch funct3; bit 1 drives BrUn_o
//   ex_pc_i, ex_target_i  EX PC and its computed taken target
//   ex_pred_taken_i       prediction made for this instruction in IF
//   BrEq_i/BrLt_i/BrGe_i  comparator flags
//   BrUn_o                comparator unsigned select (combinational)
//   redirect_o            one-cycle registered refetch pulse
//   redirect_pc_o         refetch PC, valid while redirect_o is high
//   flush_o               squash IF/ID and ID/EX, identical to redirect_o
//   branch_cnt_o          resolved conditional branches (wraps)
//   mispred_cnt_o         mispredicted conditional branches (wraps)
//
// EX handshake: an instruction resolves in the single cycle where ex_valid_i
// is high, ex_stall_i is low and no redirect is being presented. While
// redirect_o is high the EX slot holds a wrong-path instruction and is
// ignored, which also makes back-to-back redirect pulses impossible.
// -----------------------------------------------------------------------------
module branch_predictor_bht
    import riscv_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            pred_taken_o,
    input  logic            ex_valid_i,
    input  logic            ex_stall_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_is_jump_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic            BrEq_i,
    input  logic            BrLt_i,
    input  logic            BrGe_i,
    output logic            BrUn_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Registered state
    logic            redirect_q,    redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     branch_cnt_q,  branch_cnt_d;
    logic [31:0]     mispred_cnt_q, mispred_cnt_d;

    // Decode / resolve
    logic             resolve;
    logic             do_jump;
    logic             do_branch;
    logic             taken;
    logic             mispred;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    // Counter index skips the two always-zero PC bits.
    assign if_idx = if_pc_i[IDX_W+1:2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];

    // Only the index bits of the fetch PC matter to the lookup.
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

    assign BrUn_o = ex_funct3_i[1];

    assign resolve   = ex_valid_i & ~ex_stall_i & ~redirect_q;
    assign do_jump   = resolve & ex_is_jump_i;
    // Illegal funct3 is dropped entirely: no training, no count, no redirect.
    assign do_branch = resolve & ex_is_branch_i & ~ex_is_jump_i
                     & funct3_legal(ex_funct3_i);
    assign taken     = branch_taken(ex_funct3_i, BrEq_i, BrLt_i, BrGe_i);
    assign mispred   = do_branch & (taken != ex_pred_taken_i);

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (if_idx),
        .rd_taken_o (pred_taken_o),
        .wr_en_i    (do_branch),
        .wr_idx_i   (ex_idx),
        .wr_taken_i (taken)
    );

    always_comb begin
        redirect_d    = do_jump | mispred;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (do_jump) begin
            redirect_pc_d = ex_target_i;
        end else if (mispred) begin
            // Refetch the real path: the target if taken, else fall-through.
            redirect_pc_d = taken ? ex_target_i : (ex_pc_i + XLEN'(4));
        end

        if (do_branch) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispred) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign redirect_o    = redirect_q;
    assign flush_o       = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
// Directed bench. Drivers push the expected redirect PC whenever a resolve
// should produce a redirect; a monitor on the falling edge pops and compares
// each time the DUT raises redirect_o/flush_o. Counts, BrUn and lookups are
// compared directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;
    import riscv_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic        ex_valid_i;
    logic        ex_stall_i;
    logic        ex_is_branch_i;
    logic        ex_is_jump_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic        BrEq_i, BrLt_i, BrGe_i;
    logic        BrUn_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    branch_predictor_bht #(.BHT_ENTRIES(64), .XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc_i),
        .pred_taken_o    (pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_stall_i      (ex_stall_i),
        .ex_is_branch_i  (ex_is_branch_i),
        .ex_is_jump_i    (ex_is_jump_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pc_i         (ex_pc_i),
        .ex_target_i     (ex_target_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .BrEq_i          (BrEq_i),
        .BrLt_i          (BrLt_i),
        .BrGe_i          (BrGe_i),
        .BrUn_o          (BrUn_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .branch_cnt_o    (branch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
        if_pc_i = pc;
        #1;
        check(name, {31'd0, pred_taken_o}, {31'd0, exp});
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] br, input logic [31:0] mp);
        check({name, " branch_cnt"}, branch_cnt_o, br);
        check({name, " mispred_cnt"}, mispred_cnt_o, mp);
    endtask

    // ---------------- driver ----------------
    task automatic clear_ex();
        ex_valid_i = 1'b0; ex_stall_i = 1'b0;
        ex_is_branch_i = 1'b0; ex_is_jump_i = 1'b0;
    endtask

    task automatic drive_ex(input logic br, input logic jmp, input logic [2:0] f3,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pred, input logic eq, input logic lt, input logic ge);
        ex_valid_i = 1'b1; ex_stall_i = 1'b0;
        ex_is_branch_i = br; ex_is_jump_i = jmp; ex_funct3_i = f3;
        ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pred;
        BrEq_i = eq; BrLt_i = lt; BrGe_i = ge;
    endtask

    // One resolve cycle, then one idle cycle (where any redirect is shown).
    task automatic issue(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic eq, input logic lt, input logic ge,
                         input logic exp_red, input logic [31:0] exp_pc);
        @(posedge clk_i); #1;
        drive_ex(br, jmp, f3, pc, tgt, pred, eq, lt, ge);
        if (exp_red) exp_q.push_back(exp_pc);
        @(posedge clk_i); #1;
        clear_ex();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (redirect_o || flush_o) begin
            check("flush_eq_redirect", {31'd0, flush_o}, {31'd0, redirect_o});
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_redirect: got pc %08h expected no redirect", redirect_pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                tests_run--;
                check("redirect_pc", redirect_pc_o, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1; if_pc_i = '0; ex_funct3_i = '0; ex_pc_i = '0; ex_target_i = '0;
        ex_pred_taken_i = 1'b0; BrEq_i = 1'b0; BrLt_i = 1'b0; BrGe_i = 1'b0;
        clear_ex();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        chk_pred("reset_pred", 32'h100, 1'b0);
        chk_cnt("reset", 32'd0, 32'd0);
        check("reset_redirect", {31'd0, redirect_o}, 32'd0);
        check("reset_flush", {31'd0, flush_o}, 32'd0);
        check("reset_redirect_pc", redirect_pc_o, 32'd0);

        // Taken BEQ, mispredicted twice: idx0 01->10->11
        issue(1, 0, F3_BEQ, 32'h100, 32'h80, 0, 1, 0, 0, 1, 32'h80);
        chk_cnt("beq1", 32'd1, 32'd1);
        issue(1, 0, F3_BEQ, 32'h100, 32'h80, 0, 1, 0, 0, 1, 32'h80);
        chk_cnt("beq2", 32'd2, 32'd2);
        chk_pred("beq_trained", 32'h100, 1'b1);

        // BrUn follows funct3[1]
        ex_funct3_i = F3_BLTU; #1;
        check("brun_bltu", {31'd0, BrUn_o}, 32'd1);
        ex_funct3_i = F3_BLT; #1;
        check("brun_blt", {31'd0, BrUn_o}, 32'd0);

        // Not-taken BLTU at top of address space: fall-through wraps to 0, idx63 01->00
        issue(1, 0, F3_BLTU, 32'hFFFF_FFFC, 32'h40, 1, 0, 0, 1, 1, 32'h0000_0000);
        chk_cnt("bltu_nt", 32'd3, 32'd3);
        chk_pred("bltu_pred", 32'hFFFF_FFFC, 1'b0);
        // Taken now moves 00->01, still predicts not taken (proves the decrement)
        issue(1, 0, F3_BLTU, 32'hFFFF_FFFC, 32'h40, 0, 0, 1, 0, 1, 32'h40);
        chk_cnt("bltu_t", 32'd4, 32'd4);
        chk_pred("bltu_decremented", 32'hFFFF_FFFC, 1'b0);

        // Saturation at idx4 with BNE taken: 01->10->11->11->11->11
        issue(1, 0, F3_BNE, 32'h10, 32'h200, 0, 0, 0, 0, 1, 32'h200);
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, F3_BNE, 32'h10, 32'h200, 1, 0, 0, 0, 0, 32'h0);
        end
        chk_cnt("sat", 32'd9, 32'd5);
        // One not-taken from saturated 11 -> 10, still predicts taken
        issue(1, 0, F3_BNE, 32'h10, 32'h200, 1, 1, 0, 0, 1, 32'h14);
        chk_pred("sat_after_nt1", 32'h10, 1'b1);
        issue(1, 0, F3_BNE, 32'h10, 32'h200, 1, 1, 0, 0, 1, 32'h14);
        chk_pred("sat_after_nt2", 32'h10, 1'b0);
        chk_cnt("sat_nt", 32'd11, 32'd7);

        // Squash: BGE mispredict, then a wrong-path BEQ presented during redirect
        @(posedge clk_i); #1;
        drive_ex(1, 0, F3_BGE, 32'h20, 32'h300, 0, 0, 0, 1);
        exp_q.push_back(32'h300);
        @(posedge clk_i); #1;
        drive_ex(1, 0, F3_BEQ, 32'h24, 32'h400, 0, 1, 0, 0);
        @(posedge clk_i); #1;
        clear_ex();
        chk_cnt("squash", 32'd12, 32'd8);
        chk_pred("squash_no_train", 32'h24, 1'b0);

        // Stall: mispredicting BGE (not taken, pred 1) held for 3 cycles
        @(posedge clk_i); #1;
        drive_ex(1, 0, F3_BGE, 32'h30, 32'h500, 1, 0, 1, 0);
        ex_stall_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk_cnt("stall_hold", 32'd12, 32'd8);
        ex_stall_i = 1'b0;
        exp_q.push_back(32'h34);
        @(posedge clk_i); #1;
        clear_ex();
        chk_cnt("stall_release", 32'd13, 32'd9);
        @(posedge clk_i); #1;

        // Illegal funct3 010: no count, no redirect, no training at idx16
        issue(1, 0, 3'b010, 32'h40, 32'h600, 1, 1, 1, 1, 0, 32'h0);
        chk_cnt("illegal", 32'd13, 32'd9);
        chk_pred("illegal_no_train", 32'h40, 1'b0);

        // JAL: redirect to target, counts unchanged
        issue(0, 1, 3'b000, 32'h50, 32'h2000, 0, 0, 0, 0, 1, 32'h2000);
        chk_cnt("jal", 32'd13, 32'd9);
        // Jump and branch both high: jump wins, branch not counted or trained
        issue(1, 1, F3_BEQ, 32'h60, 32'h3000, 1, 1, 0, 0, 1, 32'h3000);
        chk_cnt("jump_wins", 32'd13, 32'd9);
        chk_pred("jump_wins_no_train", 32'h60, 1'b0);

        // Reset in the resolve cycle overrides the redirect
        @(posedge clk_i); #1;
        drive_ex(1, 0, F3_BEQ, 32'h100, 32'h80, 0, 1, 0, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        clear_ex();
        check("rst_mid_redirect", {31'd0, redirect_o}, 32'd0);
        check("rst_mid_redirect_pc", redirect_pc_o, 32'd0);
        chk_cnt("rst_mid", 32'd0, 32'd0);
        chk_pred("rst_mid_table", 32'h100, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
